video_compositor: RTL and testbench

- Parametrised, pipelined successor to the single-overlay video mux.
- Selects one of four background sources, then composites NUM_LAYERS overlay layers in priority order. Each layer has a per-layer enable and a blend mode.
- Registered pipeline: coordinates and valid travel with the pixel.
- Configuration is frame-atomic: it is latched at the first pixel of each frame. Sits between the camera/threshold/trajectory generators and the HDMI/TMDS output path.

---
 rtl/video_compositor_pkg.sv | 56 +++++
 rtl/video_compositor_blend_stage.sv | 79 +++++++
 rtl/video_compositor.sv | 145 ++++++++++++++
 tb/tb_video_compositor.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/video_compositor_pkg.sv
// Shared types and per-channel blend arithmetic for the video compositor.
package video_compositor_pkg;

    localparam int PIX_W = 24;

    typedef enum logic [1:0] {
        BG_CAMERA  = 2'd0,
        BG_CHANNEL = 2'd1,
        BG_MASK    = 2'd2,
        BG_MASK_Y  = 2'd3
    } bg_sel_t;

    typedef enum logic [1:0] {
        BLEND_KEYED  = 2'd0,
        BLEND_OPAQUE = 2'd1,
        BLEND_AVG    = 2'd2,
        BLEND_ADD    = 2'd3
    } blend_mode_t;

    function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [7:0] b);
        logic [8:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[8] ? 8'hFF : sum[7:0];
    endfunction

    function automatic logic [7:0] avg8(input logic [7:0] a, input logic [7:0] b);
        logic [8:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[8:1];
    endfunction

    // Channels are blended independently; nothing carries between them.
    function automatic logic [PIX_W-1:0] blend_pixel(input logic [PIX_W-1:0] base,
                                                     input logic [PIX_W-1:0] layer,
                                                     input blend_mode_t      mode);
        logic [PIX_W-1:0] result;
        result = base;
        case (mode)
            BLEND_KEYED:  result = (layer != '0) ? layer : base;
            BLEND_OPAQUE: result = layer;
            BLEND_AVG: begin
                for (int c = 0; c < 3; c++) begin
                    result[8*c +: 8] = avg8(base[8*c +: 8], layer[8*c +: 8]);
                end
            end
            BLEND_ADD: begin
                for (int c = 0; c < 3; c++) begin
                    result[8*c +: 8] = sat_add8(base[8*c +: 8], layer[8*c +: 8]);
                end
            end
            default: result = base;
        endcase
        return result;
    endfunction

endpackage

// File: rtl/video_compositor_blend_stage.sv
// One registered overlay stage: blends layer LAYER_IDX over the incoming pixel and
// forwards coordinates, valid and the per-pixel config to the next stage.
module video_compositor_blend_stage
    import video_compositor_pkg::*;
#(
    parameter int NUM_LAYERS = 2,
    parameter int LAYER_IDX  = 0,
    parameter int HWIDTH     = 11,
    parameter int VWIDTH     = 10
) (
    input  logic                        clk_in,
    input  logic                        rst_in,
    input  logic [PIX_W-1:0]            pixel_in,
    input  logic [PIX_W*NUM_LAYERS-1:0] layers_in,
    input  logic [NUM_LAYERS-1:0]       en_in,
    input  logic [2*NUM_LAYERS-1:0]     mode_in,
    input  logic [HWIDTH-1:0]           hcount_in,
    input  logic [VWIDTH-1:0]           vcount_in,
    input  logic                        valid_in,
    output logic [PIX_W-1:0]            pixel_out,
    output logic [PIX_W*NUM_LAYERS-1:0] layers_out,
    output logic [NUM_LAYERS-1:0]       en_out,
    output logic [2*NUM_LAYERS-1:0]     mode_out,
    output logic [HWIDTH-1:0]           hcount_out,
    output logic [VWIDTH-1:0]           vcount_out,
    output logic                        valid_out
);

    logic [PIX_W-1:0]            pixel_d, pixel_q;
    logic [PIX_W*NUM_LAYERS-1:0] layers_d, layers_q;
    logic [NUM_LAYERS-1:0]       en_d, en_q;
    logic [2*NUM_LAYERS-1:0]     mode_d, mode_q;
    logic [HWIDTH-1:0]           hcount_d, hcount_q;
    logic [VWIDTH-1:0]           vcount_d, vcount_q;
    logic                        valid_d, valid_q;

    always_comb begin
        pixel_d = pixel_in;
        if (en_in[LAYER_IDX]) begin
            pixel_d = blend_pixel(pixel_in, layers_in[PIX_W*LAYER_IDX +: PIX_W],
                                  blend_mode_t'(mode_in[2*LAYER_IDX +: 2]));
        end
        layers_d = layers_in;
        en_d     = en_in;
        mode_d   = mode_in;
        hcount_d = hcount_in;
        vcount_d = vcount_in;
        valid_d  = valid_in;
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            pixel_q  <= '0;
            layers_q <= '0;
            en_q     <= '0;
            mode_q   <= '0;
            hcount_q <= '0;
            vcount_q <= '0;
            valid_q  <= 1'b0;
        end else begin
            pixel_q  <= pixel_d;
            layers_q <= layers_d;
            en_q     <= en_d;
            mode_q   <= mode_d;
            hcount_q <= hcount_d;
            vcount_q <= vcount_d;
            valid_q  <= valid_d;
        end
    end

    assign pixel_out  = pixel_q;
    assign layers_out = layers_q;
    assign en_out     = en_q;
    assign mode_out   = mode_q;
    assign hcount_out = hcount_q;
    assign vcount_out = vcount_q;
    assign valid_out  = valid_q;

endmodule

// File: rtl/video_compositor.sv
// Pipelined video compositor: background select followed by NUM_LAYERS blend stages.
// Config is shadowed at each frame start and travels alongside its pixel.
module video_compositor
    import video_compositor_pkg::*;
#(
    parameter int          NUM_LAYERS   = 2,
    parameter int          HWIDTH       = 11,
    parameter int          VWIDTH       = 10,
    parameter logic [23:0] THRESH_COLOR = 24'hFF77AA
) (
    input  logic                        clk_in,
    input  logic                        rst_in,
    input  logic [1:0]                  bg_sel_in,
    input  logic [23:0]                 camera_pixel_in,
    input  logic [7:0]                  camera_y_in,
    input  logic [7:0]                  channel_in,
    input  logic                        thresholded_pixel_in,
    input  logic [24*NUM_LAYERS-1:0]    layer_pixel_in,
    input  logic [NUM_LAYERS-1:0]       layer_en_in,
    input  logic [2*NUM_LAYERS-1:0]     layer_mode_in,
    input  logic [HWIDTH-1:0]           hcount_in,
    input  logic [VWIDTH-1:0]           vcount_in,
    input  logic                        valid_in,
    output logic [23:0]                 pixel_out,
    output logic [HWIDTH-1:0]           hcount_out,
    output logic [VWIDTH-1:0]           vcount_out,
    output logic                        valid_out
);

    logic                        frame_start;
    bg_sel_t                     shadow_bg_sel_d, shadow_bg_sel_q;
    logic [NUM_LAYERS-1:0]       shadow_en_d, shadow_en_q;
    logic [2*NUM_LAYERS-1:0]     shadow_mode_d, shadow_mode_q;
    logic [PIX_W-1:0]            bg_d, bg_q;
    logic [PIX_W*NUM_LAYERS-1:0] layers_d, layers_q;
    logic [NUM_LAYERS-1:0]       en_d, en_q;
    logic [2*NUM_LAYERS-1:0]     mode_d, mode_q;
    logic [HWIDTH-1:0]           hcount_d, hcount_q;
    logic [VWIDTH-1:0]           vcount_d, vcount_q;
    logic                        valid_d, valid_q;

    // The shadow's next value doubles as the effective config, so the frame-start
    // pixel already sees the freshly captured settings.
    always_comb begin
        frame_start     = valid_in && (hcount_in == '0) && (vcount_in == '0);
        shadow_bg_sel_d = shadow_bg_sel_q;
        shadow_en_d     = shadow_en_q;
        shadow_mode_d   = shadow_mode_q;
        if (frame_start) begin
            shadow_bg_sel_d = bg_sel_t'(bg_sel_in);
            shadow_en_d     = layer_en_in;
            shadow_mode_d   = layer_mode_in;
        end

        bg_d = camera_pixel_in;
        case (shadow_bg_sel_d)
            BG_CAMERA:  bg_d = camera_pixel_in;
            BG_CHANNEL: bg_d = {3{channel_in}};
            BG_MASK:    bg_d = thresholded_pixel_in ? 24'hFFFFFF : 24'h000000;
            BG_MASK_Y:  bg_d = thresholded_pixel_in ? THRESH_COLOR : {3{camera_y_in}};
            default:    bg_d = camera_pixel_in;
        endcase

        layers_d = layer_pixel_in;
        en_d     = shadow_en_d;
        mode_d   = shadow_mode_d;
        hcount_d = hcount_in;
        vcount_d = vcount_in;
        valid_d  = valid_in;
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            shadow_bg_sel_q <= BG_CAMERA;
            shadow_en_q     <= '0;
            shadow_mode_q   <= '0;
            bg_q            <= '0;
            layers_q        <= '0;
            en_q            <= '0;
            mode_q          <= '0;
            hcount_q        <= '0;
            vcount_q        <= '0;
            valid_q         <= 1'b0;
        end else begin
            shadow_bg_sel_q <= shadow_bg_sel_d;
            shadow_en_q     <= shadow_en_d;
            shadow_mode_q   <= shadow_mode_d;
            bg_q            <= bg_d;
            layers_q        <= layers_d;
            en_q            <= en_d;
            mode_q          <= mode_d;
            hcount_q        <= hcount_d;
            vcount_q        <= vcount_d;
            valid_q         <= valid_d;
        end
    end

    logic [PIX_W-1:0]            pix_chain    [NUM_LAYERS+1];
    logic [PIX_W*NUM_LAYERS-1:0] layers_chain [NUM_LAYERS+1];
    logic [NUM_LAYERS-1:0]       en_chain     [NUM_LAYERS+1];
    logic [2*NUM_LAYERS-1:0]     mode_chain   [NUM_LAYERS+1];
    logic [HWIDTH-1:0]           hcount_chain [NUM_LAYERS+1];
    logic [VWIDTH-1:0]           vcount_chain [NUM_LAYERS+1];
    logic                        valid_chain  [NUM_LAYERS+1];

    assign pix_chain[0]    = bg_q;
    assign layers_chain[0] = layers_q;
    assign en_chain[0]     = en_q;
    assign mode_chain[0]   = mode_q;
    assign hcount_chain[0] = hcount_q;
    assign vcount_chain[0] = vcount_q;
    assign valid_chain[0]  = valid_q;

    for (genvar k = 0; k < NUM_LAYERS; k++) begin : g_layer
        video_compositor_blend_stage #(
            .NUM_LAYERS (NUM_LAYERS),
            .LAYER_IDX  (k),
            .HWIDTH     (HWIDTH),
            .VWIDTH     (VWIDTH)
        ) u_stage (
            .clk_in     (clk_in),
            .rst_in     (rst_in),
            .pixel_in   (pix_chain[k]),
            .layers_in  (layers_chain[k]),
            .en_in      (en_chain[k]),
            .mode_in    (mode_chain[k]),
            .hcount_in  (hcount_chain[k]),
            .vcount_in  (vcount_chain[k]),
            .valid_in   (valid_chain[k]),
            .pixel_out  (pix_chain[k+1]),
            .layers_out (layers_chain[k+1]),
            .en_out     (en_chain[k+1]),
            .mode_out   (mode_chain[k+1]),
            .hcount_out (hcount_chain[k+1]),
            .vcount_out (vcount_chain[k+1]),
            .valid_out  (valid_chain[k+1])
        );
    end

    assign pixel_out  = valid_chain[NUM_LAYERS] ? pix_chain[NUM_LAYERS] : 24'h000000;
    assign hcount_out = hcount_chain[NUM_LAYERS];
    assign vcount_out = vcount_chain[NUM_LAYERS];
    assign valid_out  = valid_chain[NUM_LAYERS];

endmodule

// File: tb/tb_video_compositor.sv
// Directed self-checking bench for video_compositor with two overlay layers.
module tb_video_compositor;

    localparam int NUM_LAYERS = 2;
    localparam int HWIDTH     = 11;
    localparam int VWIDTH     = 10;
    localparam int LAT        = NUM_LAYERS + 1;

    logic                     clk_in = 1'b0;
    logic                     rst_in;
    logic [1:0]               bg_sel_in;
    logic [23:0]              camera_pixel_in;
    logic [7:0]               camera_y_in;
    logic [7:0]               channel_in;
    logic                     thresholded_pixel_in;
    logic [24*NUM_LAYERS-1:0] layer_pixel_in;
    logic [NUM_LAYERS-1:0]    layer_en_in;
    logic [2*NUM_LAYERS-1:0]  layer_mode_in;
    logic [HWIDTH-1:0]        hcount_in;
    logic [VWIDTH-1:0]        vcount_in;
    logic                     valid_in;
    logic [23:0]              pixel_out;
    logic [HWIDTH-1:0]        hcount_out;
    logic [VWIDTH-1:0]        vcount_out;
    logic                     valid_out;

    int checks = 0;
    int errors = 0;

    video_compositor #(
        .NUM_LAYERS   (NUM_LAYERS),
        .HWIDTH       (HWIDTH),
        .VWIDTH       (VWIDTH),
        .THRESH_COLOR (24'hFF77AA)
    ) dut (
        .clk_in               (clk_in),
        .rst_in               (rst_in),
        .bg_sel_in            (bg_sel_in),
        .camera_pixel_in      (camera_pixel_in),
        .camera_y_in          (camera_y_in),
        .channel_in           (channel_in),
        .thresholded_pixel_in (thresholded_pixel_in),
        .layer_pixel_in       (layer_pixel_in),
        .layer_en_in          (layer_en_in),
        .layer_mode_in        (layer_mode_in),
        .hcount_in            (hcount_in),
        .vcount_in            (vcount_in),
        .valid_in             (valid_in),
        .pixel_out            (pixel_out),
        .hcount_out           (hcount_out),
        .vcount_out           (vcount_out),
        .valid_out            (valid_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    // One frame-start beat so its config is captured, then bubbles until it exits.
    task automatic send_frame_pixel(output logic [23:0] pix, output logic vld);
        valid_in  = 1'b1;
        hcount_in = '0;
        vcount_in = '0;
        step();
        valid_in  = 1'b0;
        hcount_in = 11'd1;
        step();
        step();
        pix = pixel_out;
        vld = valid_out;
    endtask

    task automatic test_reset();
        int first_seen;
        rst_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bg_sel_in            = 2'($urandom());
            camera_pixel_in      = 24'($urandom());
            camera_y_in          = 8'($urandom());
            channel_in           = 8'($urandom());
            thresholded_pixel_in = 1'($urandom());
            layer_pixel_in       = {24'($urandom()), 24'($urandom())};
            layer_en_in          = 2'($urandom());
            layer_mode_in        = 4'($urandom());
            hcount_in            = 11'($urandom());
            vcount_in            = 10'($urandom());
            valid_in             = 1'($urandom());
            step();
            checks++;
            if (pixel_out !== 24'h0) begin
                errors++;
                $display("[TB] FAIL reset_pixel cycle %0d: got %h expected 000000", i, pixel_out);
            end
            checks++;
            if (hcount_out !== '0) begin
                errors++;
                $display("[TB] FAIL reset_hcount cycle %0d: got %h expected 0", i, hcount_out);
            end
            checks++;
            if (vcount_out !== '0) begin
                errors++;
                $display("[TB] FAIL reset_vcount cycle %0d: got %h expected 0", i, vcount_out);
            end
            checks++;
            if (valid_out !== 1'b0) begin
                errors++;
                $display("[TB] FAIL reset_valid cycle %0d: got %b expected 0", i, valid_out);
            end
        end
        rst_in    = 1'b0;
        valid_in  = 1'b0;
        hcount_in = 11'd3;
        vcount_in = 10'd3;
        step();
        step();
        checks++;
        if (valid_out !== 1'b0) begin
            errors++;
            $display("[TB] FAIL post_reset_idle_valid: got %b expected 0", valid_out);
        end
        valid_in   = 1'b1;
        hcount_in  = '0;
        vcount_in  = '0;
        first_seen = 0;
        for (int k = 1; k <= LAT + 3; k++) begin
            step();
            valid_in  = 1'b0;
            hcount_in = 11'd1;
            if (valid_out === 1'b1 && first_seen == 0) first_seen = k;
        end
        checks++;
        if (first_seen != LAT) begin
            errors++;
            $display("[TB] FAIL first_valid_latency: got %0d expected %0d (0 means never)", first_seen, LAT);
        end
    endtask

    task automatic test_reset_mid_frame();
        valid_in        = 1'b1;
        camera_pixel_in = 24'hABCDEF;
        hcount_in       = '0;
        vcount_in       = '0;
        step();
        hcount_in = 11'd1;
        step();
        rst_in   = 1'b1;
        valid_in = 1'b0;
        step();
        rst_in = 1'b0;
        for (int k = 0; k < LAT; k++) begin
            step();
            checks++;
            if (valid_out !== 1'b0 || pixel_out !== 24'h0) begin
                errors++;
                $display("[TB] FAIL mid_frame_flush cycle %0d: got valid %b pixel %h expected 0 000000",
                         k, valid_out, pixel_out);
            end
        end
    endtask

    task automatic test_bg_modes();
        logic [1:0]  bg_t   [6] = '{2'd0, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3};
        logic        mask_t [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
        logic [23:0] exp_t  [6] = '{24'h123456, 24'h808080, 24'hFFFFFF,
                                    24'h000000, 24'h404040, 24'hFF77AA};
        logic [23:0] pix;
        logic        vld;
        camera_pixel_in = 24'h123456;
        channel_in      = 8'h80;
        camera_y_in     = 8'h40;
        layer_en_in     = 2'b00;
        layer_mode_in   = 4'b0101;
        layer_pixel_in  = {24'h0000FF, 24'h00FF00};
        for (int i = 0; i < 6; i++) begin
            bg_sel_in            = bg_t[i];
            thresholded_pixel_in = mask_t[i];
            send_frame_pixel(pix, vld);
            checks++;
            if (vld !== 1'b1 || pix !== exp_t[i]) begin
                errors++;
                $display("[TB] FAIL bg_mode_%0d_mask_%0b: got valid %b pixel %h expected 1 %h",
                         bg_t[i], mask_t[i], vld, pix, exp_t[i]);
            end
        end
    endtask

    task automatic test_blend_modes();
        logic [1:0]  en_t    [6] = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b00};
        logic [1:0]  mode_t  [6] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
        logic [23:0] layer_t [6] = '{24'h000000, 24'h000000, 24'h10FF00,
                                     24'h200510, 24'h123456, 24'h000000};
        logic [23:0] exp_t   [6] = '{24'hF0F0F0, 24'h000000, 24'h80F778,
                                     24'hFFF5FF, 24'h123456, 24'hF0F0F0};
        logic [23:0] pix;
        logic        vld;
        bg_sel_in       = 2'd0;
        camera_pixel_in = 24'hF0F0F0;
        for (int i = 0; i < 6; i++) begin
            layer_en_in    = en_t[i];
            layer_mode_in  = {2'b00, mode_t[i]};
            layer_pixel_in = {24'hFFFFFF, layer_t[i]};
            send_frame_pixel(pix, vld);
            checks++;
            if (vld !== 1'b1 || pix !== exp_t[i]) begin
                errors++;
                $display("[TB] FAIL blend_case_%0d mode %0d en %b: got valid %b pixel %h expected 1 %h",
                         i, mode_t[i], en_t[i], vld, pix, exp_t[i]);
            end
        end
    endtask

    task automatic test_priority();
        logic [47:0] layers_t [3] = '{{24'h00FF00, 24'h0000FF}, {24'h000000, 24'h0000FF},
                                      {24'h000000, 24'h000000}};
        logic [3:0]  mode_t   [3] = '{4'b0000, 4'b0000, 4'b0001};
        logic [23:0] exp_t    [3] = '{24'h00FF00, 24'h0000FF, 24'h000000};
        logic [23:0] pix;
        logic        vld;
        bg_sel_in       = 2'd0;
        camera_pixel_in = 24'hF0F0F0;
        layer_en_in     = 2'b11;
        for (int i = 0; i < 3; i++) begin
            layer_pixel_in = layers_t[i];
            layer_mode_in  = mode_t[i];
            send_frame_pixel(pix, vld);
            checks++;
            if (vld !== 1'b1 || pix !== exp_t[i]) begin
                errors++;
                $display("[TB] FAIL priority_case_%0d: got valid %b pixel %h expected 1 %h",
                         i, vld, pix, exp_t[i]);
            end
        end
    endtask

    // Config changes at beat 5 of frame A must wait for the (0,0) beat of frame B,
    // and frame A's tail still in flight keeps the old settings.
    task automatic test_frame_atomic();
        logic [23:0] exp_pix [10];
        logic [10:0] exp_h   [10];
        bg_sel_in       = 2'd0;
        camera_pixel_in = 24'hF0F0F0;
        channel_in      = 8'h11;
        layer_en_in     = 2'b00;
        layer_mode_in   = 4'b0001;
        layer_pixel_in  = {24'h000000, 24'h0000FF};
        for (int j = 0; j < 12; j++) begin
            if (j < 10) begin
                exp_pix[j] = (j < 8) ? 24'hF0F0F0 : 24'h0000FF;
                exp_h[j]   = (j < 8) ? 11'(j) : 11'(j - 8);
                valid_in   = 1'b1;
                hcount_in  = exp_h[j];
                vcount_in  = '0;
                if (j == 5) begin
                    layer_en_in = 2'b01;
                    bg_sel_in   = 2'd1;
                end
            end else begin
                valid_in  = 1'b0;
                hcount_in = 11'd50;
                vcount_in = 10'd50;
            end
            step();
            if (j >= LAT - 1) begin
                checks++;
                if (valid_out !== 1'b1 || pixel_out !== exp_pix[j-2] || hcount_out !== exp_h[j-2]) begin
                    errors++;
                    $display("[TB] FAIL frame_atomic_beat_%0d: got valid %b pixel %h h %0d expected 1 %h h %0d",
                             j - 2, valid_out, pixel_out, hcount_out, exp_pix[j-2], exp_h[j-2]);
                end
            end
        end
        valid_in = 1'b0;
        step();
    endtask

    task automatic test_alignment();
        localparam int N = 40;
        logic [23:0] cam_h [N];
        logic [10:0] h_h   [N];
        logic [9:0]  v_h   [N];
        logic        vld_h [N];
        logic [23:0] exp_pix;
        bg_sel_in   = 2'd0;
        layer_en_in = 2'b00;
        for (int j = 0; j < N + 2; j++) begin
            if (j < N) begin
                cam_h[j] = 24'($urandom());
                h_h[j]   = (j == 0) ? 11'd0 : 11'(j + 100);
                v_h[j]   = (j == 0) ? 10'd0 : 10'(j % 7 + 1);
                vld_h[j] = (j == 0) ? 1'b1 : 1'($urandom_range(0, 1));
                camera_pixel_in = cam_h[j];
                hcount_in       = h_h[j];
                vcount_in       = v_h[j];
                valid_in        = vld_h[j];
            end else begin
                valid_in  = 1'b0;
                hcount_in = '0;
                vcount_in = '0;
            end
            step();
            if (j >= LAT - 1) begin
                exp_pix = vld_h[j-2] ? cam_h[j-2] : 24'h000000;
                checks++;
                if (hcount_out !== h_h[j-2] || vcount_out !== v_h[j-2]) begin
                    errors++;
                    $display("[TB] FAIL align_coords_beat_%0d: got h %0d v %0d expected h %0d v %0d",
                             j - 2, hcount_out, vcount_out, h_h[j-2], v_h[j-2]);
                end
                checks++;
                if (valid_out !== vld_h[j-2] || pixel_out !== exp_pix) begin
                    errors++;
                    $display("[TB] FAIL align_pixel_beat_%0d: got valid %b pixel %h expected %b %h",
                             j - 2, valid_out, pixel_out, vld_h[j-2], exp_pix);
                end
            end
        end
    endtask

    initial begin
        rst_in               = 1'b1;
        bg_sel_in            = '0;
        camera_pixel_in      = '0;
        camera_y_in          = '0;
        channel_in           = '0;
        thresholded_pixel_in = 1'b0;
        layer_pixel_in       = '0;
        layer_en_in          = '0;
        layer_mode_in        = '0;
        hcount_in            = '0;
        vcount_in            = '0;
        valid_in             = 1'b0;
        test_reset();
        test_reset_mid_frame();
        test_bg_modes();
        test_blend_modes();
        test_priority();
        test_frame_atomic();
        test_alignment();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
